alu_mdu_unit: RTL and testbench
===============================

Name: alu_mdu_unit

Overview:
- Execute-stage arithmetic unit for the pipelined RISC-V core, parametrised in data width XLEN.
- Decodes ALUOp/funct3/funct7 and computes the integer result.
- Single-cycle ops (add, sub, and, xor, sll, sra) return one cycle after issue.
- RV32M ops (mul/mulh/mulhsu/mulhu/div/divu/rem/remu) run on an iterative multi-cycle datapath; busy_o stalls the pipeline while they run.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- valid_i  in  1  issue strobe; sampled only in IDLE
- flush_i  in  1  abort any in-flight op; no result produced
- ALUOp_i  in  2  00 add (srai when funct3=101), 01 sub, 10 R-type decode, 11 pass rs2
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- rs1_data_i  in  XLEN  operand A
- rs2_data_i  in  XLEN  operand B; shift amount is rs2[$clog2(XLEN)-1:0]
- result_o  out  XLEN  registered result, held until next completion
- valid_o  out  1  one-cycle completion pulse
- busy_o  out  1  high in every state except IDLE; drives the hazard-unit stall

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; result_o=0; valid_o=0; busy_o=0.
  - All iteration registers are cleared.
- Decode with ALUOp=10:
  - funct7=0000001 selects an M op by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Otherwise funct3 111 AND, 100 XOR, 001 SLL, 101 SRA, 000 ADD (SUB when funct7[5]=1).
  - Any other funct3 gives result 0, with single-cycle timing.
- States: IDLE, ITER, FIX, DONE.
- IDLE → DONE: valid_i with a single-cycle op. The result is latched at that edge, so valid_o rises the next cycle (latency 1).
- IDLE → ITER: valid_i with an M op.
  - Latch |A| and |B| (absolute values where the op is signed) and the result-sign flags.
  - Counter is loaded with XLEN.
- ITER, multiply: one shift-add step per cycle over a 2*XLEN product register.
- ITER, divide: one restoring step per cycle (shift remainder, trial subtract, set quotient bit).
- ITER → FIX when the counter reaches 0 (exactly XLEN ITER cycles).
- FIX applies the sign correction:
  - Two's-complement negate where required.
  - Select the low word (MUL) or high word (MULH*), or quotient/remainder; the result is latched.
- DONE: valid_o=1 for exactly one cycle, then unconditional return to IDLE.
- M-op latency from issue edge to valid_o is XLEN+2 cycles (34 at XLEN=32).
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = dividend. Uses normal latency.
- Signed overflow, DIV with MIN / −1: quotient = MIN, remainder = 0.
- Arithmetic wraps modulo 2^XLEN. SRA sign-fills; SLL zero-fills.
- valid_i outside IDLE is ignored; no queueing. The upstream stage must hold its instruction while busy_o=1.
- flush_i:
  - Forces IDLE on the next edge from any state.
  - valid_o stays 0 (a DONE pulse already showing in that cycle is suppressed).
  - result_o is unchanged.
  - flush_i together with valid_i in IDLE: the issue is discarded.
- rst_i mid-operation aborts immediately, asynchronously, and restores reset values.

Optional Feature:
- Macro: ALU_MDU_FAST_BYPASS_EN.
- Defined:
  - IDLE detects these M-op cases: divisor = 0, either mul operand = 0, or the divide overflow case.
  - For these it writes the final result directly and goes to DONE, giving latency 1.
- Undefined: every M op takes XLEN+2 cycles, with results identical to the defined case.

Decomposition:
- Package alu_pkg holds:
  - ALUOp encodings, funct3/funct7 constants and the M-op funct7 value.
  - An op enum: ADD, SUB, AND, XOR, SLL, SRA, PASS, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - The state enum: IDLE, ITER, FIX, DONE.
- Sub-module mdu_iter_core: the shared shift-add / restoring-divide datapath, counter and done flag.
- The top level holds decode, the single-cycle ALU, the FSM and sign fixup.

Test Plan:
- Reset/idle: assert rst_i mid-ITER → result_o=0, busy_o=0 immediately. Then ADD 7+5 → valid_o one cycle after issue, result 12.
- R-type basics at XLEN=32:
  - SUB 3−5 → 0xFFFFFFFE.
  - SRA 0x80000000 by 4 → 0xF8000000.
  - SLL 1 by 31 → 0x80000000.
  - XOR, AND exercised against a reference model.
- Multiply:
  - MUL 0xFFFFFFFF*2 → 0xFFFFFFFE.
  - MULH −1*−1 → 0.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE.
  - Each: busy_o high for 34 cycles, valid_o at issue+34.
- Divide corners:
  - DIV −7/2 → −3, REM → −1.
  - DIVU 7/0 → 0xFFFFFFFF, REMU → 7.
  - DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Flush/ignore: issue DIV; pulse valid_i at cycle 5 → ignored. flush_i at cycle 10 → IDLE next cycle, no valid_o, result_o unchanged.
- Macro build: with ALU_MDU_FAST_BYPASS_EN, DIVU 7/0 completes at latency 1 with identical result. Rerun the full suite at XLEN=16 and XLEN=64 with a randomised model comparison.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU / multiply-divide unit:
// ALUOp and funct3/funct7 encodings, the internal op enum, the FSM state
// enum and the instruction decoder used by alu_mdu_unit.
package alu_pkg;

  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned F7_W    = 7;

  // ALUOp encodings from the main decoder
  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [ALUOP_W-1:0] ALUOP_PASS  = 2'b11;

  // Base-ISA funct3 values
  localparam logic [F3_W-1:0] F3_ADD = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL = 3'b001;
  localparam logic [F3_W-1:0] F3_XOR = 3'b100;
  localparam logic [F3_W-1:0] F3_SR  = 3'b101;
  localparam logic [F3_W-1:0] F3_AND = 3'b111;

  // RV32M funct3 values
  localparam logic [F3_W-1:0] F3_MUL    = 3'b000;
  localparam logic [F3_W-1:0] F3_MULH   = 3'b001;
  localparam logic [F3_W-1:0] F3_MULHSU = 3'b010;
  localparam logic [F3_W-1:0] F3_MULHU  = 3'b011;
  localparam logic [F3_W-1:0] F3_DIV    = 3'b100;
  localparam logic [F3_W-1:0] F3_DIVU   = 3'b101;
  localparam logic [F3_W-1:0] F3_REM    = 3'b110;
  localparam logic [F3_W-1:0] F3_REMU   = 3'b111;

  localparam logic [F7_W-1:0] F7_MEXT = 7'b0000001;

  // OP_NONE covers undefined R-type funct3 values (result 0)
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_PASS,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_NONE
  } op_e;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  // Instruction fields to internal op
  function automatic op_e decode_op(input logic [ALUOP_W-1:0] aluop,
                                    input logic [F3_W-1:0]    f3,
                                    input logic [F7_W-1:0]    f7);
    op_e op;
    op = OP_NONE;
    case (aluop)
      ALUOP_ADD:  op = (f3 == F3_SR) ? OP_SRA : OP_ADD;
      ALUOP_SUB:  op = OP_SUB;
      ALUOP_PASS: op = OP_PASS;
      default: begin
        if (f7 == F7_MEXT) begin
          case (f3)
            F3_MUL:    op = OP_MUL;
            F3_MULH:   op = OP_MULH;
            F3_MULHSU: op = OP_MULHSU;
            F3_MULHU:  op = OP_MULHU;
            F3_DIV:    op = OP_DIV;
            F3_DIVU:   op = OP_DIVU;
            F3_REM:    op = OP_REM;
            F3_REMU:   op = OP_REMU;
            default:   op = OP_NONE;
          endcase
        end else begin
          case (f3)
            F3_AND:  op = OP_AND;
            F3_XOR:  op = OP_XOR;
            F3_SLL:  op = OP_SLL;
            F3_SR:   op = OP_SRA;
            F3_ADD:  op = f7[5] ? OP_SUB : OP_ADD;
            default: op = OP_NONE;
          endcase
        end
      end
    endcase
    return op;
  endfunction

  function automatic logic is_mop(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_mdu_unit_if.sv
// Issue/result bundle between the pipeline and alu_mdu_unit.
//   slave  : the unit (receives issue fields, drives result/valid/busy)
//   master : the issuing pipeline stage
interface alu_mdu_unit_if #(parameter int unsigned XLEN = 32);
  logic            valid_i;
  logic            flush_i;
  logic [1:0]      ALUOp_i;
  logic [2:0]      funct3_i;
  logic [6:0]      funct7_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic            busy_o;

  modport slave (
    input  valid_i, flush_i, ALUOp_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i,
    output result_o, valid_o, busy_o
  );

  modport master (
    output valid_i, flush_i, ALUOp_i, funct3_i, funct7_i, rs1_data_i, rs2_data_i,
    input  result_o, valid_o, busy_o
  );
endinterface

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: shift-add multiply and restoring divide over
// one 2*XLEN accumulator, plus the iteration counter.
//   load_i   : start, acc = {0, a_i}, divisor/multiplicand = b_i, cnt = XLEN
//   step_i   : perform one iteration while cnt != 0
//   is_div_i : selects divide (else multiply), sampled on load_i
//   acc_o    : multiply -> 2*XLEN product; divide -> {remainder, quotient}
//   done_c   : the current step is the last one
module mdu_iter_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              done_c
);
  localparam int unsigned PW = 2 * XLEN;

  logic [PW-1:0]    acc_q, acc_next;
  logic [XLEN-1:0]  b_q;
  logic             is_div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0] mul_sum, div_shift, div_trial;

  // One iteration step for either operation
  always_comb begin
    mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, b_q};
    div_shift = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, b_q};
    acc_next  = acc_q;
    if (is_div_q) begin
      // Borrow means the trial failed: keep the shifted remainder, bit 0
      if (div_trial[XLEN])
        acc_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
        acc_next = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      if (acc_q[0])
        acc_next = {mul_sum, acc_q[XLEN-1:1]};
      else
        acc_next = {1'b0, acc_q[PW-1:1]};
    end
  end

  assign done_c = (cnt_q == CNT_W'(1));
  assign acc_o  = acc_q;

  // Iteration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (load_i) begin
      acc_q    <= {{XLEN{1'b0}}, a_i};
      b_q      <= b_i;
      is_div_q <= is_div_i;
      cnt_q    <= CNT_W'(XLEN);
    end else if (step_i && (cnt_q != '0)) begin
      acc_q    <= acc_next;
      cnt_q    <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_mdu_unit.sv
// Execute-stage integer unit: single-cycle ALU ops (latency 1) and RV32M
// multiply/divide on an iterative datapath (latency XLEN+2).
// Ports:
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : valid_i/flush_i issue controls, ALUOp_i/funct3_i/funct7_i
//                  decode fields, rs1_data_i/rs2_data_i operands;
//                  result_o (held until next completion), valid_o (one-cycle
//                  completion pulse), busy_o (high whenever not IDLE)
// Build option: ALU_MDU_FAST_BYPASS_EN finishes trivial M ops (zero divisor,
// zero mul operand, signed divide overflow) in one cycle.
module alu_mdu_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_mdu_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  state_e          state_q, state_d;
  op_e             op_c, op_q;
  logic [XLEN-1:0] a, b, alu_res_c, fix_res_c;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q, valid_d, busy_q;
  logic            load_c;
  logic [SH_W-1:0] shamt;

  logic            a_neg, b_neg, neg_res_c, neg_rem_c, neg_res_q, neg_rem_q;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [PW-1:0]   acc, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            core_done;

  assign a     = bus.rs1_data_i;
  assign b     = bus.rs2_data_i;
  assign shamt = b[SH_W-1:0];
  assign op_c  = decode_op(bus.ALUOp_i, bus.funct3_i, bus.funct7_i);

  // Single-cycle ALU
  always_comb begin
    alu_res_c = '0;
    case (op_c)
      OP_ADD:  alu_res_c = a + b;
      OP_SUB:  alu_res_c = a - b;
      OP_AND:  alu_res_c = a & b;
      OP_XOR:  alu_res_c = a ^ b;
      OP_SLL:  alu_res_c = a << shamt;
      OP_SRA:  alu_res_c = XLEN'($signed(a) >>> shamt);
      OP_PASS: alu_res_c = b;
      default: alu_res_c = '0;
    endcase
  end

  // Operand magnitudes and result-sign flags; MUL's low word is sign-agnostic
  always_comb begin
    a_neg = (op_c inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & a[XLEN-1];
    b_neg = (op_c inside {OP_MULH, OP_DIV, OP_REM}) & b[XLEN-1];
    a_abs = a_neg ? (~a + XLEN'(1)) : a;
    b_abs = b_neg ? (~b + XLEN'(1)) : b;
    // A zero divisor leaves the all-ones quotient unsigned
    neg_res_c = is_div(op_c) ? ((a_neg ^ b_neg) & (b != '0)) : (a_neg ^ b_neg);
    neg_rem_c = a_neg;
  end

`ifdef ALU_MDU_FAST_BYPASS_EN
  logic            byp_hit_c;
  logic [XLEN-1:0] byp_res_c;

  // Trivial M-op results computed directly from the operands
  always_comb begin
    byp_hit_c = 1'b0;
    byp_res_c = '0;
    if (is_div(op_c)) begin
      if (b == '0) begin
        byp_hit_c = 1'b1;
        byp_res_c = (op_c inside {OP_DIV, OP_DIVU}) ? '1 : a;
      end else if ((op_c inside {OP_DIV, OP_REM}) && (b == '1) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}})) begin
        byp_hit_c = 1'b1;
        byp_res_c = (op_c == OP_DIV) ? a : '0;
      end
    end else if (is_mop(op_c) && ((a == '0) || (b == '0))) begin
      byp_hit_c = 1'b1;
      byp_res_c = '0;
    end
  end
`endif

  mdu_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load_c),
    .step_i   (state_q == ITER),
    .is_div_i (is_div(op_c)),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .acc_o    (acc),
    .done_c   (core_done)
  );

  // Sign fixup and word select from the finished accumulator
  always_comb begin
    prod_fix  = neg_res_q ? (~acc + PW'(1)) : acc;
    quo_fix   = neg_res_q ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    rem_fix   = neg_rem_q ? (~acc[PW-1:XLEN] + XLEN'(1)) : acc[PW-1:XLEN];
    fix_res_c = '0;
    case (op_q)
      OP_MUL:                       fix_res_c = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res_c = quo_fix;
      OP_REM, OP_REMU:              fix_res_c = rem_fix;
      default:                      fix_res_c = '0;
    endcase
  end

  // Next state, result and completion
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    valid_d  = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          if (is_mop(op_c)) begin
`ifdef ALU_MDU_FAST_BYPASS_EN
            if (byp_hit_c) begin
              result_d = byp_res_c;
              valid_d  = 1'b1;
              state_d  = DONE;
            end else begin
              load_c  = 1'b1;
              state_d = ITER;
            end
`else
            load_c  = 1'b1;
            state_d = ITER;
`endif
          end else begin
            result_d = alu_res_c;
            valid_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      ITER: if (core_done) state_d = FIX;
      FIX: begin
        result_d = fix_res_c;
        valid_d  = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including an issue in IDLE
    if (bus.flush_i) begin
      state_d  = IDLE;
      result_d = result_q;
      valid_d  = 1'b0;
      load_c   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      result_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      op_q      <= OP_ADD;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d != IDLE);
      if (load_c) begin
        op_q      <= op_c;
        neg_res_q <= neg_res_c;
        neg_rem_q <= neg_rem_c;
      end
    end
  end

  assign bus.result_o = result_q;
  // A flush in the DONE cycle must hide the pulse that is already showing
  assign bus.valid_o  = valid_q & ~bus.flush_i;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Directed bench for alu_mdu_unit at XLEN=32: a vector table with
// hand-computed results, a model-checked random batch, and hand-written
// reset / ignore / flush sequences.
module tb_alu_mdu_unit;
  localparam int unsigned XLEN = 32;
  localparam int          M_LAT = XLEN + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_unit_if #(.XLEN(XLEN)) bus ();
  alu_mdu_unit #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct {
    logic [1:0]  aluop;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  localparam logic [6:0] F7B = 7'b0000000;
  localparam logic [6:0] F7S = 7'b0100000;
  localparam logic [6:0] F7M = 7'b0000001;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] aluop, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.aluop = aluop; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  // Issue-to-valid latency expected for a given instruction
  function automatic int exp_lat(input vec_t v);
    if (!(v.aluop == 2'b10 && v.f7 == F7M)) return 1;
`ifdef ALU_MDU_FAST_BYPASS_EN
    if (v.f3[2]) begin
      if (v.b == 32'h0) return 1;
      if (!v.f3[0] && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF) return 1;
    end else if (v.a == 32'h0 || v.b == 32'h0) return 1;
`endif
    return M_LAT;
  endfunction

  // Independent reference built on 64-bit arithmetic
  function automatic logic [31:0] model(input vec_t v);
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ovf;
    sh  = v.b[4:0];
    ovf = (v.a == 32'h8000_0000) && (v.b == 32'hFFFF_FFFF);
    case (v.aluop)
      2'b00: return (v.f3 == 3'b101) ? 32'($signed(v.a) >>> sh) : v.a + v.b;
      2'b01: return v.a - v.b;
      2'b11: return v.b;
      default: ;
    endcase
    if (v.f7 == F7M) begin
      case (v.f3)
        3'd0: begin p = {32'h0, v.a} * {32'h0, v.b}; return p[31:0]; end
        3'd1: begin p = {{32{v.a[31]}}, v.a} * {{32{v.b[31]}}, v.b}; return p[63:32]; end
        3'd2: begin p = {{32{v.a[31]}}, v.a} * {32'h0, v.b}; return p[63:32]; end
        3'd3: begin p = {32'h0, v.a} * {32'h0, v.b}; return p[63:32]; end
        3'd4: return (v.b == 0) ? 32'hFFFF_FFFF : ovf ? v.a : 32'($signed(v.a) / $signed(v.b));
        3'd5: return (v.b == 0) ? 32'hFFFF_FFFF : v.a / v.b;
        3'd6: return (v.b == 0) ? v.a : ovf ? 32'h0 : 32'($signed(v.a) % $signed(v.b));
        default: return (v.b == 0) ? v.a : v.a % v.b;
      endcase
    end
    case (v.f3)
      3'b111: return v.a & v.b;
      3'b100: return v.a ^ v.b;
      3'b001: return v.a << sh;
      3'b101: return 32'($signed(v.a) >>> sh);
      3'b000: return v.f7[5] ? v.a - v.b : v.a + v.b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.ALUOp_i    = v.aluop;
    bus.funct3_i   = v.f3;
    bus.funct7_i   = v.f7;
    bus.rs1_data_i = v.a;
    bus.rs2_data_i = v.b;
    bus.valid_i    = 1'b1;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
  endtask

  // Issue one op, wait (bounded) for completion, check result/latency/busy
  task automatic run_op(input vec_t v, input string name);
    int lat, busy_n, el;
    lat = 0; busy_n = 0; el = exp_lat(v);
    drive(v);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.busy_o) busy_n++;
      if (bus.valid_o) begin lat = c; break; end
    end
    check({name, " latency"}, 64'(lat), 64'(el));
    check({name, " result"}, 64'(bus.result_o), 64'(v.exp));
    check({name, " busy cycles"}, 64'(busy_n), 64'(el));
    @(negedge clk);
    check({name, " back to idle"}, {62'h0, bus.valid_o, bus.busy_o}, 64'h0);
  endtask

  initial begin
    int lat, pulses;
    vec_t v;

    rst = 1'b1;
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    bus.ALUOp_i = '0; bus.funct3_i = '0; bus.funct7_i = '0;
    bus.rs1_data_i = '0; bus.rs2_data_i = '0;

    vecs.push_back(mk(2'b00, 3'b000, F7B, 32'd7, 32'd5, 32'd12));
    vecs.push_back(mk(2'b01, 3'b000, F7B, 32'd3, 32'd5, 32'hFFFF_FFFE));
    vecs.push_back(mk(2'b10, 3'b000, F7S, 32'd10, 32'd3, 32'd7));
    vecs.push_back(mk(2'b10, 3'b000, F7B, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000));
    vecs.push_back(mk(2'b10, 3'b101, F7S, 32'h8000_0000, 32'd4, 32'hF800_0000));
    vecs.push_back(mk(2'b00, 3'b101, F7S, 32'h8000_0010, 32'h24, 32'hF800_0001));
    vecs.push_back(mk(2'b10, 3'b001, F7B, 32'd1, 32'd31, 32'h8000_0000));
    vecs.push_back(mk(2'b10, 3'b001, F7B, 32'd3, 32'd33, 32'd6));
    vecs.push_back(mk(2'b10, 3'b100, F7B, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00));
    vecs.push_back(mk(2'b10, 3'b111, F7B, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0));
    vecs.push_back(mk(2'b11, 3'b000, F7B, 32'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
    vecs.push_back(mk(2'b10, 3'b010, F7B, 32'd9, 32'd9, 32'h0));
    vecs.push_back(mk(2'b10, 3'b000, F7M, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE));
    vecs.push_back(mk(2'b10, 3'b001, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(2'b10, 3'b011, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE));
    vecs.push_back(mk(2'b10, 3'b010, F7M, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b10, 3'b001, F7M, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
    vecs.push_back(mk(2'b10, 3'b000, F7M, 32'd0, 32'd5, 32'h0));
    vecs.push_back(mk(2'b10, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
    vecs.push_back(mk(2'b10, 3'b110, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b10, 3'b101, F7M, 32'd7, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b10, 3'b111, F7M, 32'd7, 32'd0, 32'd7));
    vecs.push_back(mk(2'b10, 3'b100, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
    vecs.push_back(mk(2'b10, 3'b110, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mk(2'b10, 3'b100, F7M, 32'd7, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'b10, 3'b110, F7M, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9));
    vecs.push_back(mk(2'b10, 3'b101, F7M, 32'd100, 32'd7, 32'd14));
    vecs.push_back(mk(2'b10, 3'b111, F7M, 32'd100, 32'd7, 32'd2));
    vecs.push_back(mk(2'b10, 3'b100, F7M, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD));
    vecs.push_back(mk(2'b10, 3'b110, F7M, 32'd7, 32'hFFFF_FFFE, 32'd1));

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.result_o, 30'h0, bus.valid_o, bus.busy_o}, 64'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

    // Random batch against the reference model, corner operands mixed in
    for (int i = 0; i < 24; i++) begin
      v.aluop = (i % 4 == 3) ? 2'($urandom_range(0, 3)) : 2'b10;
      v.f3    = 3'($urandom_range(0, 7));
      v.f7    = (i % 4 == 2) ? F7B : F7M;
      v.a     = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
      v.b     = (i % 6 == 0) ? 32'h0 : (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      v.exp   = model(v);
      run_op(v, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of an iteration
    run_op(mk(2'b00, 3'b000, F7B, 32'd7, 32'd5, 32'd12), "pre-reset add");
    drive(mk(2'b10, 3'b101, F7M, 32'd100, 32'd7, 32'd0));
    repeat (5) @(negedge clk);
    check("busy mid-iter", 64'(bus.busy_o), 64'h1);
    #2 rst = 1'b1;
    #1 check("async reset", {bus.result_o, 30'h0, bus.valid_o, bus.busy_o}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(mk(2'b00, 3'b000, F7B, 32'd7, 32'd5, 32'd12), "post-reset add");

    // valid_i while busy is ignored
    drive(mk(2'b10, 3'b101, F7M, 32'd100, 32'd7, 32'd0));
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.ALUOp_i = 2'b00; bus.funct3_i = 3'b000; bus.funct7_i = F7B;
        bus.rs1_data_i = 32'd1; bus.rs2_data_i = 32'd1; bus.valid_i = 1'b1;
      end
      if (c == 6) bus.valid_i = 1'b0;
      if (bus.valid_o) begin lat = c; break; end
    end
    check("ignore latency", 64'(lat), 64'(M_LAT));
    check("ignore result", 64'(bus.result_o), 64'd14);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (bus.valid_o) pulses++; end
    check("ignore no extra pulse", 64'(pulses), 64'h0);

    // Flush mid-divide: idle next cycle, no pulse, result held
    drive(mk(2'b10, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'd0));
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush busy", 64'(bus.busy_o), 64'h0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin @(negedge clk); if (bus.valid_o) pulses++; end
    check("flush no pulse", 64'(pulses), 64'h0);
    check("flush result held", 64'(bus.result_o), 64'd14);

    // Flush together with issue in IDLE discards the issue
    @(negedge clk);
    bus.ALUOp_i = 2'b00; bus.funct3_i = 3'b000; bus.funct7_i = F7B;
    bus.rs1_data_i = 32'd1; bus.rs2_data_i = 32'd1;
    bus.valid_i = 1'b1; bus.flush_i = 1'b1;
    @(posedge clk);
    #1 begin bus.valid_i = 1'b0; bus.flush_i = 1'b0; end
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.valid_o || bus.busy_o) pulses++;
    end
    check("flush+issue discarded", 64'(pulses), 64'h0);
    check("flush+issue result", 64'(bus.result_o), 64'd14);

    // Flush during DONE hides the pulse
    drive(mk(2'b00, 3'b000, F7B, 32'd2, 32'd2, 32'd0));
    @(negedge clk);
    bus.flush_i = 1'b1;
    #1 check("flush hides done pulse", 64'(bus.valid_o), 64'h0);
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("after done flush", {62'h0, bus.valid_o, bus.busy_o}, 64'h0);

    run_op(mk(2'b10, 3'b011, F7M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE), "final mulhu");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
